// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
// State enum, opcode/funct codes, ALU op codes and mux select encodings.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_ADDI_EX  = 4'd8,
        S_ADDI_WB  = 4'd9,
        S_BEQ_EX   = 4'd10,
        S_JUMP_EX  = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        AM_ADD   = 2'd0,
        AM_SUB   = 2'd1,
        AM_FUNCT = 2'd2
    } alu_mode_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    function automatic logic funct_legal(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_AND) || (f == FN_OR) ||
               (f == FN_SUB) || (f == FN_SLT);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU op decoder: mode (add/sub/funct) + funct -> alu_op.
// Ports: mode, funct[5:0] in; alu_op[OP_W-1:0] out (3-bit code zero-extended).
module alu_decoder
    import ctrl_pkg::*;
#(
    parameter int OP_W = 3
) (
    input  alu_mode_t        mode,
    input  logic [5:0]       funct,
    output logic [OP_W-1:0]  alu_op
);

    logic [2:0] base;

    always_comb begin
        base = ALU_ADD;
        unique case (mode)
            AM_SUB: base = ALU_SUB;
            AM_FUNCT: begin
                case (funct)
                    FN_ADD:  base = ALU_ADD;
                    FN_AND:  base = ALU_AND;
                    FN_OR:   base = ALU_OR;
                    FN_SUB:  base = ALU_SUB;
                    FN_SLT:  base = ALU_SLT;
                    default: base = ALU_ADD;
                endcase
            end
            default: base = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_op      = '0;
        alu_op[2:0] = base;
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/mem/wb,
// drives datapath strobes and mux selects, flags illegal ops, counts retires.
// Ports: clk, rst, instr[31:0], mem_ready, zero in; datapath controls,
// alu_op, illegal, instr_count[CNT_W-1:0], state[3:0] out.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int OP_W          = 3,
    parameter int MEM_HANDSHAKE = 1,
    parameter int EN_BRANCH     = 1,
    parameter int CNT_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic              mem_ready,
    input  logic              zero,
    output logic [OP_W-1:0]   alu_op,
    output logic              regwrite,
    output logic              regdst,
    output logic              memtoreg,
    output logic              alusrc_a,
    output logic [1:0]        alusrc_b,
    output logic              mem_read,
    output logic              mem_write,
    output logic              iord,
    output logic              irwrite,
    output logic              pcwrite,
    output logic [1:0]        pc_src,
    output logic              illegal,
    output logic [CNT_W-1:0]  instr_count,
    output logic [3:0]        state
);

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;
    logic [5:0] fn_q;
    logic [CNT_W-1:0] cnt_q;
    alu_mode_t  mode;
    logic       mr;
    logic       retire;
    logic       dec_bad;
    logic       unused_instr;

    assign unused_instr = ^instr[25:6];

    assign mr = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    assign retire = (state_q == S_MEMWB) ||
                    (state_q == S_MEMWR && mr) ||
                    (state_q == S_RTYPE_WB) ||
                    (state_q == S_ADDI_WB) ||
                    (state_q == S_BEQ_EX) ||
                    (state_q == S_JUMP_EX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            fn_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= instr[31:26];
                fn_q <= instr[5:0];
            end
            if (retire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // DECODE steers on the live instr; later states see only op_q/fn_q.
    always_comb begin
        state_d   = state_q;
        dec_bad   = 1'b0;
        mode      = AM_ADD;
        regwrite  = 1'b0;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        alusrc_a  = 1'b0;
        alusrc_b  = SRCB_RT;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        iord      = 1'b0;
        irwrite   = 1'b0;
        pcwrite   = 1'b0;
        pc_src    = PC_ALU;
        illegal   = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                alusrc_b = SRCB_FOUR;
                if (mr) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrc_b = SRCB_IMMSH;
                case (instr[31:26])
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_legal(instr[5:0])) state_d = S_RTYPE_EX;
                        else dec_bad = 1'b1;
                    end
                    OP_ADDI: state_d = S_ADDI_EX;
                    OP_BEQ: begin
                        if (EN_BRANCH != 0) state_d = S_BEQ_EX;
                        else dec_bad = 1'b1;
                    end
                    OP_J: begin
                        if (EN_BRANCH != 0) state_d = S_JUMP_EX;
                        else dec_bad = 1'b1;
                    end
                    default: dec_bad = 1'b1;
                endcase
                if (dec_bad) begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEMADR: begin
                alusrc_a = 1'b1;
                alusrc_b = SRCB_IMM;
                state_d  = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mr) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mr) state_d = S_FETCH;
            end
            S_RTYPE_EX: begin
                alusrc_a = 1'b1;
                mode     = AM_FUNCT;
                state_d  = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDI_EX: begin
                alusrc_a = 1'b1;
                alusrc_b = SRCB_IMM;
                state_d  = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQ_EX: begin
                alusrc_a = 1'b1;
                mode     = AM_SUB;
                pc_src   = PC_ALUOUT;
                pcwrite  = zero;
                state_d  = S_FETCH;
            end
            S_JUMP_EX: begin
                pc_src  = PC_JUMP;
                pcwrite = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // Strobes are held low for the whole reset pulse, so an in-flight
        // store is dropped immediately rather than at the next edge.
        if (rst) begin
            regwrite  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            irwrite   = 1'b0;
            pcwrite   = 1'b0;
            illegal   = 1'b0;
        end
    end

    alu_decoder #(
        .OP_W (OP_W)
    ) u_alu_dec (
        .mode   (mode),
        .funct  (fn_q),
        .alu_op (alu_op)
    );

    assign instr_count = cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle scoreboard of
// expected state/control vectors and retire count against two DUT variants.
module tb_multicycle_controller;
    import ctrl_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic [2:0] op;
        logic       rw;
        logic       rd;
        logic       m2r;
        logic       sa;
        logic [1:0] sb;
        logic       mr;
        logic       mw;
        logic       iord;
        logic       irw;
        logic       pcw;
        logic [1:0] ps;
        logic       ill;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ready;
    logic        zero;

    logic [2:0]  a_alu_op;
    logic        a_regwrite, a_regdst, a_memtoreg, a_alusrc_a;
    logic [1:0]  a_alusrc_b, a_pc_src;
    logic        a_mem_read, a_mem_write, a_iord, a_irwrite, a_pcwrite;
    logic        a_illegal;
    logic [3:0]  a_cnt;
    logic [3:0]  a_state;

    logic [2:0]  b_alu_op;
    logic        b_regwrite, b_regdst, b_memtoreg, b_alusrc_a;
    logic [1:0]  b_alusrc_b, b_pc_src;
    logic        b_mem_read, b_mem_write, b_iord, b_irwrite, b_pcwrite;
    logic        b_illegal;
    logic [31:0] b_cnt;
    logic [3:0]  b_state;

    obs_t obs_a;
    obs_t obs_b;

    int   errors = 0;
    int   checks = 0;
    int   c = 0;
    logic [2:0] rop = 3'b000;

    obs_t exp_q[$];
    int   cnt_q[$];

    always #5 clk = ~clk;

    multicycle_controller #(.CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
        .zero(zero), .alu_op(a_alu_op), .regwrite(a_regwrite),
        .regdst(a_regdst), .memtoreg(a_memtoreg), .alusrc_a(a_alusrc_a),
        .alusrc_b(a_alusrc_b), .mem_read(a_mem_read),
        .mem_write(a_mem_write), .iord(a_iord), .irwrite(a_irwrite),
        .pcwrite(a_pcwrite), .pc_src(a_pc_src), .illegal(a_illegal),
        .instr_count(a_cnt), .state(a_state)
    );

    multicycle_controller #(.EN_BRANCH(0)) dut_b (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
        .zero(zero), .alu_op(b_alu_op), .regwrite(b_regwrite),
        .regdst(b_regdst), .memtoreg(b_memtoreg), .alusrc_a(b_alusrc_a),
        .alusrc_b(b_alusrc_b), .mem_read(b_mem_read),
        .mem_write(b_mem_write), .iord(b_iord), .irwrite(b_irwrite),
        .pcwrite(b_pcwrite), .pc_src(b_pc_src), .illegal(b_illegal),
        .instr_count(b_cnt), .state(b_state)
    );

    assign obs_a = '{a_state, a_alu_op, a_regwrite, a_regdst, a_memtoreg,
                     a_alusrc_a, a_alusrc_b, a_mem_read, a_mem_write,
                     a_iord, a_irwrite, a_pcwrite, a_pc_src, a_illegal};
    assign obs_b = '{b_state, b_alu_op, b_regwrite, b_regdst, b_memtoreg,
                     b_alusrc_a, b_alusrc_b, b_mem_read, b_mem_write,
                     b_iord, b_irwrite, b_pcwrite, b_pc_src, b_illegal};

    // Expected Moore outputs for a state, from the control table.
    function automatic obs_t spec(input logic [3:0] st, input bit mrdy,
                                  input bit ill);
        obs_t o;
        o    = '0;
        o.st = st;
        case (st)
            S_FETCH: begin
                o.mr = 1'b1; o.sb = 2'b01; o.irw = mrdy; o.pcw = mrdy;
            end
            S_DECODE:   begin o.sb = 2'b11; o.ill = ill; end
            S_MEMADR:   begin o.sa = 1'b1; o.sb = 2'b10; end
            S_MEMRD:    begin o.mr = 1'b1; o.iord = 1'b1; end
            S_MEMWB:    begin o.rw = 1'b1; o.m2r = 1'b1; end
            S_MEMWR:    begin o.mw = 1'b1; o.iord = 1'b1; end
            S_RTYPE_EX: begin o.sa = 1'b1; o.op = rop; end
            S_RTYPE_WB: begin o.rw = 1'b1; o.rd = 1'b1; end
            S_ADDI_EX:  begin o.sa = 1'b1; o.sb = 2'b10; end
            S_ADDI_WB:  begin o.rw = 1'b1; end
            S_BEQ_EX: begin
                o.sa = 1'b1; o.op = 3'b011; o.ps = 2'b01; o.pcw = zero;
            end
            S_JUMP_EX:  begin o.ps = 2'b10; o.pcw = 1'b1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: drive mem_ready, queue expectation, compare at negedge.
    task automatic step(input logic [3:0] st, input bit mrdy, input bit ill,
                        input int cnt, input string tag);
        obs_t e;
        int   ec;
        mem_ready = mrdy;
        exp_q.push_back(spec(st, mrdy, ill));
        cnt_q.push_back(cnt & 15);
        @(negedge clk);
        e  = exp_q.pop_front();
        ec = cnt_q.pop_front();
        chk(tag, 64'(obs_a), 64'(e));
        chk({tag, "_cnt"}, 64'(a_cnt), 64'(ec));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        obs_t e;
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1;
        e    = '0;
        e.sb = 2'b01;
        chk({tag, "_a"}, 64'(obs_a), 64'(e));
        chk({tag, "_acnt"}, 64'(a_cnt), 64'd0);
        chk({tag, "_bst"}, 64'(b_state), 64'(S_FETCH));
        @(posedge clk);
        #1;
        rst = 1'b0;
        c   = 0;
    endtask

    logic [31:0] rt_i[5] = '{32'h00221820, 32'h00221822, 32'h00221824,
                             32'h00221825, 32'h0022182A};
    logic [2:0]  rt_o[5] = '{3'b000, 3'b011, 3'b100, 3'b010, 3'b111};

    initial begin
        instr     = 32'h0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        rst       = 1'b1;
        #2;
        do_reset("rst0");

        for (int i = 0; i < 5; i++) begin
            instr = rt_i[i];
            rop   = rt_o[i];
            step(S_FETCH, 1, 0, c, "rt_f");
            step(S_DECODE, 1, 0, c, "rt_d");
            step(S_RTYPE_EX, 1, 0, c, "rt_ex");
            step(S_RTYPE_WB, 1, 0, c, "rt_wb");
            c++;
        end

        instr = 32'h8C220004;
        step(S_FETCH, 1, 0, c, "lw_f");
        step(S_DECODE, 1, 0, c, "lw_d");
        instr = 32'hFFFFFFFF;
        step(S_MEMADR, 1, 0, c, "lw_adr");
        step(S_MEMRD, 0, 0, c, "lw_rd0");
        step(S_MEMRD, 0, 0, c, "lw_rd1");
        step(S_MEMRD, 0, 0, c, "lw_rd2");
        step(S_MEMRD, 1, 0, c, "lw_rd3");
        step(S_MEMWB, 1, 0, c, "lw_wb");
        c++;

        instr = 32'hAC220004;
        step(S_FETCH, 0, 0, c, "sw_fw");
        step(S_FETCH, 1, 0, c, "sw_f");
        step(S_DECODE, 1, 0, c, "sw_d");
        step(S_MEMADR, 1, 0, c, "sw_adr");
        step(S_MEMWR, 1, 0, c, "sw_wr");
        c++;

        instr = 32'hAC220004;
        step(S_FETCH, 1, 0, c, "swr_f");
        step(S_DECODE, 1, 0, c, "swr_d");
        step(S_MEMADR, 1, 0, c, "swr_adr");
        step(S_MEMWR, 0, 0, c, "swr_wr");
        #3;
        chk("swr_mw_hold", 64'(a_mem_write), 64'd1);
        rst = 1'b1;
        #1;
        chk("swr_mw_drop", 64'(a_mem_write), 64'd0);
        chk("swr_st_rst", 64'(a_state), 64'(S_FETCH));
        @(posedge clk);
        #1;
        rst = 1'b0;
        c   = 0;

        instr = 32'h10220003;
        zero  = 1'b1;
        step(S_FETCH, 1, 0, c, "beq1_f");
        step(S_DECODE, 1, 0, c, "beq1_d");
        step(S_BEQ_EX, 1, 0, c, "beq1_ex");
        c++;
        zero = 1'b0;
        step(S_FETCH, 1, 0, c, "beq0_f");
        step(S_DECODE, 1, 0, c, "beq0_d");
        step(S_BEQ_EX, 1, 0, c, "beq0_ex");
        c++;

        instr = 32'hFC000000;
        step(S_FETCH, 1, 0, c, "ill_f");
        step(S_DECODE, 1, 1, c, "ill_d");

        instr = 32'h08000010;
        step(S_FETCH, 1, 0, c, "j_f");
        step(S_DECODE, 1, 0, c, "j_d");
        step(S_JUMP_EX, 1, 0, c, "j_ex");
        c++;
        step(S_FETCH, 0, 0, c, "j_post");

        do_reset("rst1");
        instr = 32'h20220005;
        for (int i = 0; i < 16; i++) begin
            step(S_FETCH, 1, 0, c, "addi_f");
            step(S_DECODE, 1, 0, c, "addi_d");
            step(S_ADDI_EX, 1, 0, c, "addi_ex");
            step(S_ADDI_WB, 1, 0, c, "addi_wb");
            c++;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        chk("addi_wrap", 64'(a_cnt), 64'd0);
        @(posedge clk);
        #1;

        do_reset("rst2");
        instr     = 32'h08000010;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("bj_f", 64'(obs_b), 64'(spec(S_FETCH, 1, 0)));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bj_d", 64'(obs_b), 64'(spec(S_DECODE, 1, 1)));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bj_back", 64'(obs_b), 64'(spec(S_FETCH, 1, 0)));
        chk("bj_cnt", 64'(b_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle MIPS control unit, parametrised successor to the single-cycle combinational decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states.
- Drives datapath strobes and ALU op, and stalls on a memory-ready handshake.
- Adds lw/sw/beq/j to the existing add/and/or/sub/slt/addi set.
- Flags illegal instructions and counts retired instructions.

Parameters:
- OP_W, 3: ALU op width, minimum 3. Codes are zero-extended to OP_W.
- MEM_HANDSHAKE, 1: 1 = memory states wait for mem_ready; 0 = mem_ready ignored and treated as 1.
- EN_BRANCH, 1: 1 = beq/j decoded; 0 = beq/j treated as illegal.
- CNT_W, 32: retired-instruction counter width.

Ports:
- clk, input, 1: the single clock.
- rst, input, 1: asynchronous, active-high reset.
- instr, input, 32: instruction register contents.
- mem_ready, input, 1: memory access complete this cycle.
- zero, input, 1: ALU zero flag.
- alu_op, output, OP_W: add=000, and=100, or=010, sub=011, slt=111.
- regwrite, output, 1: register file write enable.
- regdst, output, 1: 1 = rd, 0 = rt.
- memtoreg, output, 1: 1 = write-back from memory data register.
- alusrc_a, output, 1: 0 = PC, 1 = rs.
- alusrc_b, output, 2: 00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- mem_read, output, 1: memory read strobe.
- mem_write, output, 1: memory write strobe.
- iord, output, 1: 0 = PC address, 1 = ALUOut address.
- irwrite, output, 1: instruction register load.
- pcwrite, output, 1: PC load.
- pc_src, output, 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal, output, 1: one-cycle illegal-instruction pulse.
- instr_count, output, CNT_W: retired-instruction count.
- state, output, 4: current state, for debug.

Behaviour:
- Reset (async, rst=1):
  - state = FETCH, instr_count = 0, latched opcode/funct = 0.
  - All strobes forced to 0 while rst is high: regwrite, mem_read, mem_write, irwrite, pcwrite, illegal.
  - Other outputs take their FETCH values.
  - Reset mid-operation aborts immediately; a pending mem_write is dropped.
- Outputs are Moore-style, decoded from state plus latched fields. Unlisted strobes are 0; unlisted mux selects are 0.
- DECODE captures instr[31:26] and instr[5:0] into internal registers. All later states use only the latched copies.
- FETCH:
  - mem_read=1, iord=0, alusrc_a=0, alusrc_b=01, alu_op=add, pc_src=00.
  - irwrite and pcwrite = 1 only in the cycle mem_ready=1.
  - Hold in FETCH while mem_ready=0; else go to DECODE.
- DECODE: alusrc_a=0, alusrc_b=11, alu_op=add (computes the branch target). Next state by opcode:
  - 100011 / 101011 -> MEMADR.
  - 000000 with legal funct (100000, 100100, 100101, 100010, 101010) -> RTYPE_EX.
  - 001000 -> ADDI_EX.
  - 000100 -> BEQ_EX (EN_BRANCH=1 only).
  - 000010 -> JUMP_EX (EN_BRANCH=1 only).
  - Anything else: illegal=1 for this cycle, then FETCH; the instruction is not counted.
- MEMADR: alusrc_a=1, alusrc_b=10, alu_op=add. Go to MEMRD if lw, else MEMWR.
- MEMRD: mem_read=1, iord=1. Hold until mem_ready, then MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1, then FETCH.
- MEMWR: mem_write=1, iord=1, held stable until mem_ready, then FETCH.
- RTYPE_EX: alusrc_a=1, alusrc_b=00, alu_op from funct, then RTYPE_WB.
- RTYPE_WB: regwrite=1, regdst=1, then FETCH.
- ADDI_EX: alusrc_a=1, alusrc_b=10, alu_op=add, then ADDI_WB.
- ADDI_WB: regwrite=1, regdst=0, then FETCH.
- BEQ_EX: alusrc_a=1, alusrc_b=00, alu_op=sub, pc_src=01, pcwrite=zero, then FETCH.
- JUMP_EX: pc_src=10, pcwrite=1, then FETCH.
- Latency with no wait states: R-type/addi 4 cycles, lw 5, sw 4, beq/j 3. Each wait cycle adds 1.
- instr_count:
  - Increments by 1 on the cycle leaving MEMWB, MEMWR (with mem_ready), RTYPE_WB, ADDI_WB, BEQ_EX or JUMP_EX.
  - Wraps modulo 2^CNT_W; illegal instructions do not increment it.
- mem_ready asserted in a non-memory state is ignored.

Decomposition:
- Package ctrl_pkg holds:
  - State enum (4-bit encoding).
  - Opcode and funct localparams.
  - ALU op constants (3-bit base codes).
  - alusrc_b and pc_src encodings.
- One sub-module, alu_decoder: combinational funct/mode -> alu_op. Modes are add, sub, funct.

Test Plan:
- Reset during MEMWR (rst=1 while mem_ready=0) -> mem_write drops to 0 in the same cycle. After release: state=FETCH, instr_count=0.
- add 0x00221820, mem_ready=1:
  - Sequence FETCH, DECODE, RTYPE_EX (alu_op=000, alusrc_a=1, alusrc_b=00), RTYPE_WB (regwrite=1, regdst=1).
  - Takes 4 cycles; instr_count becomes 1.
- lw 0x8C220004 with mem_ready=0 for 3 cycles in MEMRD -> MEMRD lasts 4 cycles with mem_read/iord stable, 8 cycles total, memtoreg=1 in MEMWB.
- beq 0x10220003:
  - zero=1 -> BEQ_EX has pcwrite=1, pc_src=01, alu_op=011.
  - zero=0 -> pcwrite=0; instr_count increments in both cases.
- Illegal opcode 0xFC000000 -> illegal high for exactly 1 cycle in DECODE, back to FETCH, instr_count unchanged. With EN_BRANCH=0, j 0x08000010 behaves the same.
- CNT_W=4, 16 addi 0x20220005 -> instr_count wraps 15 -> 0. Each addi shows alusrc_b=10 in ADDI_EX and regdst=0 in ADDI_WB.
